// File: rtl/dds_pkg.sv
// Shared definitions for the DDS receive-side meter: FSM state codes and
// offset-binary threshold helpers.
package dds_pkg;

  typedef logic [1:0] dds_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LOW   = 2'd3;

  // DDS samples are unsigned offset-binary: code MID represents zero amplitude.
  function automatic int unsigned dds_mid(input int unsigned amp_w);
    return int'(1) << (amp_w - 1);
  endfunction

  function automatic int unsigned dds_hi(input int unsigned amp_w, input int unsigned hyst);
    return dds_mid(amp_w) + hyst;
  endfunction

  function automatic int unsigned dds_lo(input int unsigned amp_w, input int unsigned hyst);
    return dds_mid(amp_w) - hyst;
  endfunction

  function automatic int dds_centered(input int unsigned code, input int unsigned amp_w);
    return int'(code) - int'(dds_mid(amp_w));
  endfunction

endpackage

// File: rtl/dds_xing_det.sv
// Hysteresis comparator for dds_meter: combinational above/below level flags
// plus a registered strobe marking each rising mid-scale crossing.
module dds_xing_det
  import dds_pkg::*;
#(
  parameter int MAX_AMP = 8,
  parameter int HYST    = 4
) (
  input  logic               clk,
  input  logic               res,
  input  logic               sample_valid,
  input  logic [MAX_AMP-1:0] sample,
  output logic               above,
  output logic               below,
  output logic               rise
);

  localparam logic [MAX_AMP-1:0] HI = MAX_AMP'(dds_hi(MAX_AMP, HYST));
  localparam logic [MAX_AMP-1:0] LO = MAX_AMP'(dds_lo(MAX_AMP, HYST));

  logic low_q, low_d;
  logic rise_q, rise_d;

  assign above = (sample >= HI);
  assign below = (sample <= LO);

  // low_q remembers which side of the band the last out-of-band sample was on
  always_comb begin
    low_d = low_q;
    if (sample_valid && below) begin
      low_d = 1'b1;
    end else if (sample_valid && above) begin
      low_d = 1'b0;
    end
    rise_d = sample_valid && above && low_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      low_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      low_q  <= low_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/dds_meter.sv
// Period and amplitude-extreme meter for a DDS sample stream. Define
// DDS_METER_AVG_EN to publish one averaged result per four waveform cycles.
module dds_meter
  import dds_pkg::*;
#(
  parameter int MAX_AMP   = 8,
  parameter int CNT_WIDTH = 16,
  parameter int HYST      = 4
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 sample_valid,
  input  logic [MAX_AMP-1:0]   sample,
  output logic                 meas_valid,
  output logic [CNT_WIDTH-1:0] period,
  output logic [MAX_AMP-1:0]   peak,
  output logic [MAX_AMP-1:0]   trough,
  output logic                 locked,
  output logic                 timeout
);

  function automatic logic [MAX_AMP-1:0] amp_max(input logic [MAX_AMP-1:0] a,
                                                 input logic [MAX_AMP-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [MAX_AMP-1:0] amp_min(input logic [MAX_AMP-1:0] a,
                                                 input logic [MAX_AMP-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic above, below, rise;

  dds_xing_det #(
    .MAX_AMP(MAX_AMP),
    .HYST   (HYST)
  ) u_xing (
    .clk         (clk),
    .res         (res),
    .sample_valid(sample_valid),
    .sample      (sample),
    .above       (above),
    .below       (below),
    .rise        (rise)
  );

  dds_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [MAX_AMP-1:0]   pk_q, pk_d;
  logic [MAX_AMP-1:0]   tr_q, tr_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [MAX_AMP-1:0]   peak_q, peak_d;
  logic [MAX_AMP-1:0]   trough_q, trough_d;
  logic                 pub_q, pub_d;
  logic                 locked_q, locked_d;
  logic                 timeout_q, timeout_d;

`ifdef DDS_METER_AVG_EN
  logic [CNT_WIDTH+1:0] acc_q, acc_d, acc_sum;
  logic [1:0]           grp_q, grp_d;
  logic [MAX_AMP-1:0]   gpk_q, gpk_d, gpk_nx;
  logic [MAX_AMP-1:0]   gtr_q, gtr_d, gtr_nx;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pk_d      = pk_q;
    tr_d      = tr_q;
    period_d  = period_q;
    peak_d    = peak_q;
    trough_d  = trough_q;
    pub_d     = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;
`ifdef DDS_METER_AVG_EN
    acc_d   = acc_q;
    grp_d   = grp_q;
    gpk_d   = gpk_q;
    gtr_d   = gtr_q;
    acc_sum = acc_q + {2'b00, cnt_q};
    gpk_nx  = amp_max(gpk_q, pk_q);
    gtr_nx  = amp_min(gtr_q, tr_q);
`endif

    if (sample_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (below) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (above) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_WIDTH'(1);
            pk_d    = sample;
            tr_d    = sample;
          end
        end
        default: begin
          if (above && (state_q == ST_LOW)) begin
            // Rising crossing: the crossing sample opens the next cycle.
`ifdef DDS_METER_AVG_EN
            if (grp_q == 2'd3) begin
              period_d = acc_sum[CNT_WIDTH+1:2];
              peak_d   = gpk_nx;
              trough_d = gtr_nx;
              pub_d    = 1'b1;
              locked_d = 1'b1;
              acc_d    = '0;
              grp_d    = 2'd0;
              gpk_d    = '0;
              gtr_d    = '1;
            end else begin
              acc_d = acc_sum;
              grp_d = grp_q + 2'd1;
              gpk_d = gpk_nx;
              gtr_d = gtr_nx;
            end
`else
            period_d = cnt_q;
            peak_d   = pk_q;
            trough_d = tr_q;
            pub_d    = 1'b1;
            locked_d = 1'b1;
`endif
            state_d = ST_HIGH;
            cnt_d   = CNT_WIDTH'(1);
            pk_d    = sample;
            tr_d    = sample;
          end else if (&cnt_q) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pk_d      = '0;
            tr_d      = '1;
`ifdef DDS_METER_AVG_EN
            acc_d = '0;
            grp_d = 2'd0;
            gpk_d = '0;
            gtr_d = '1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            pk_d  = amp_max(pk_q, sample);
            tr_d  = amp_min(tr_q, sample);
            if (below) state_d = ST_LOW;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pk_q      <= '0;
      tr_q      <= '1;
      period_q  <= '0;
      peak_q    <= '0;
      trough_q  <= '0;
      pub_q     <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef DDS_METER_AVG_EN
      acc_q <= '0;
      grp_q <= 2'd0;
      gpk_q <= '0;
      gtr_q <= '1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pk_q      <= pk_d;
      tr_q      <= tr_d;
      period_q  <= period_d;
      peak_q    <= peak_d;
      trough_q  <= trough_d;
      pub_q     <= pub_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
`ifdef DDS_METER_AVG_EN
      acc_q <= acc_d;
      grp_q <= grp_d;
      gpk_q <= gpk_d;
      gtr_q <= gtr_d;
`endif
    end
  end

  // Every publish coincides with the detector's rise strobe.
  assign meas_valid = pub_q & rise;
  assign period     = period_q;
  assign peak       = peak_q;
  assign trough     = trough_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
